// File: rtl/vcPingPongPkg.sv
// Shared definitions for the ping-pong buffer controller: per-bank state
// encoding and the width of the frames_avail count.
package vcPingPongPkg;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_e;

    localparam int FA_SZ = 2;

endpackage

// File: rtl/vcRAM_1w1r_pf.sv
// One-write one-read flip-flop RAM. Synchronous write, combinational read.
// Contents are not reset.
module vcRAM_1w1r_pf #(
    parameter int DATA_SZ = 32,
    parameter int ENTRIES = 16,
    parameter int ADDR_SZ = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_SZ-1:0] wr_addr,
    input  logic [DATA_SZ-1:0] wr_data,
    input  logic [ADDR_SZ-1:0] rd_addr,
    output logic [DATA_SZ-1:0] rd_data
);

    logic [DATA_SZ-1:0] mem_q [ENTRIES];

    // storage array write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vc_pingpong_bank_fsm.sv
// Ownership state of one buffer bank.
// Optional feature macro: VC_PINGPONG_FLUSH_EN adds a stored frame length,
// captured when the bank is closed (full frame or early flush).
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   BANK_EMPTY  | no data, producer may start a frame here
//   BANK_FILL   | producer has written part of a frame
//   BANK_FULL   | complete frame waiting, consumer not started
//   BANK_DRAIN  | consumer is reading the frame out
module vc_pingpong_bank_fsm
`ifdef VC_PINGPONG_FLUSH_EN
#(
    parameter int LEN_SZ = 5
)
`endif
(
    input  logic              clk,
    input  logic              reset_p,
    input  logic              wr_fire,
    input  logic              wr_last,
    input  logic              rd_fire,
    input  logic              rd_last,
`ifdef VC_PINGPONG_FLUSH_EN
    input  logic [LEN_SZ-1:0] wr_len,
    output logic [LEN_SZ-1:0] len,
`endif
    output logic              writable,
    output logic              readable
);

    import vcPingPongPkg::*;

    bank_state_e state_q, state_d;

    // state register
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= BANK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // next state; wr_last can arrive without wr_fire when a flush closes a
    // partly filled bank, and a frame of one word goes straight to FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            BANK_EMPTY: if (wr_fire) state_d = wr_last ? BANK_FULL : BANK_FILL;
            BANK_FILL:  if (wr_last) state_d = BANK_FULL;
            BANK_FULL:  if (rd_fire) state_d = rd_last ? BANK_EMPTY : BANK_DRAIN;
            BANK_DRAIN: if (rd_fire && rd_last) state_d = BANK_EMPTY;
            default:    state_d = BANK_EMPTY;
        endcase
    end

    assign writable = (state_q == BANK_EMPTY) || (state_q == BANK_FILL);
    assign readable = (state_q == BANK_FULL)  || (state_q == BANK_DRAIN);

`ifdef VC_PINGPONG_FLUSH_EN
    logic [LEN_SZ-1:0] len_q, len_d;

    // frame length register, loaded when the producer closes the bank
    always_ff @(posedge clk) begin
        if (reset_p) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    // capture length only on the closing write/flush
    always_comb begin
        len_d = len_q;
        if (wr_last && writable) begin
            len_d = wr_len;
        end
    end

    assign len = len_q;
`endif

`ifndef SYNTHESIS
    // protocol monitor: the top must never write a readable bank or read a writable one
    always_ff @(posedge clk) begin
        if (!reset_p && wr_fire && !writable) begin
            $display("RTL-ERROR: write into bank in state %0d", state_q);
        end
        if (!reset_p && rd_fire && !readable) begin
            $display("RTL-ERROR: read from bank in state %0d", state_q);
        end
    end
`endif

endmodule

// File: rtl/vc_pingpong_buf_ctrl.sv
// Ping-pong frame buffer controller: the producer fills one bank while the
// consumer drains the other, swapping on frame boundaries with no bubble.
// Optional feature macro: VC_PINGPONG_FLUSH_EN adds flush_p, which closes a
// partial frame early; the reader then honours the stored frame length.
module vc_pingpong_buf_ctrl #(
    parameter int DATA_SZ = 32,
    parameter int ENTRIES = 16,
    parameter int ADDR_SZ = 4
) (
    input  logic               clk,
    input  logic               reset_p,
`ifdef VC_PINGPONG_FLUSH_EN
    input  logic               flush_p,
`endif
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [DATA_SZ-1:0] in_data,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [DATA_SZ-1:0] out_data,
    output logic               out_last,
    output logic [1:0]         frames_avail
);

    import vcPingPongPkg::*;

    localparam logic [ADDR_SZ-1:0] LAST_A = ADDR_SZ'(ENTRIES - 1);
`ifdef VC_PINGPONG_FLUSH_EN
    localparam int LEN_SZ = ADDR_SZ + 1;
`endif

    logic               wbank_q, wbank_d;
    logic               rbank_q, rbank_d;
    logic [ADDR_SZ-1:0] waddr_q, waddr_d;
    logic [ADDR_SZ-1:0] raddr_q, raddr_d;

    logic [1:0]         writable;
    logic [1:0]         readable;
    logic [1:0]         bank_wr_fire;
    logic [1:0]         bank_wr_last;
    logic [1:0]         bank_rd_fire;
    logic [DATA_SZ-1:0] rd_data [2];

    logic               wr_fire;
    logic               rd_fire;
    logic               wr_close;
    logic               rd_at_last;

    assign in_rdy  = !reset_p && writable[wbank_q];
    assign out_val = !reset_p && readable[rbank_q];
    assign wr_fire = in_val && in_rdy;
    assign rd_fire = out_rdy && out_val;

`ifdef VC_PINGPONG_FLUSH_EN
    logic [LEN_SZ-1:0]  bank_len [2];
    logic [LEN_SZ-1:0]  wr_len;
    logic [LEN_SZ-1:0]  rd_len;
    logic               flush_take;

    // the write bank is in FILL exactly when waddr is non-zero, so a flush is
    // honoured whenever it accompanies a write or words are already pending
    assign flush_take = flush_p && !reset_p && (wr_fire || (waddr_q != '0));
    assign wr_len     = {1'b0, waddr_q} + LEN_SZ'(wr_fire);
    assign wr_close   = (wr_fire && (waddr_q == LAST_A)) || flush_take;
    assign rd_len     = bank_len[rbank_q];
    assign rd_at_last = ({1'b0, raddr_q} == (rd_len - LEN_SZ'(1)));
`else
    assign wr_close   = wr_fire && (waddr_q == LAST_A);
    assign rd_at_last = (raddr_q == LAST_A);
`endif

    assign out_last     = out_val && rd_at_last;
    assign out_data     = rd_data[rbank_q];
    assign frames_avail = reset_p ? 2'd0
                                  : ({1'b0, readable[0]} + {1'b0, readable[1]});

    // steer write/read events to the bank currently owned by each side
    always_comb begin
        bank_wr_fire = '0;
        bank_wr_last = '0;
        bank_rd_fire = '0;
        bank_wr_fire[wbank_q] = wr_fire;
        bank_wr_last[wbank_q] = wr_close;
        bank_rd_fire[rbank_q] = rd_fire;
    end

    // pointer next-state: addresses wrap at the frame end, not at 1<<ADDR_SZ
    always_comb begin
        wbank_d = wbank_q;
        waddr_d = waddr_q;
        rbank_d = rbank_q;
        raddr_d = raddr_q;
        if (wr_close) begin
            waddr_d = '0;
            wbank_d = ~wbank_q;
        end else if (wr_fire) begin
            waddr_d = waddr_q + ADDR_SZ'(1);
        end
        if (rd_fire) begin
            if (rd_at_last) begin
                raddr_d = '0;
                rbank_d = ~rbank_q;
            end else begin
                raddr_d = raddr_q + ADDR_SZ'(1);
            end
        end
    end

    // pointer registers
    always_ff @(posedge clk) begin
        if (reset_p) begin
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
        end else begin
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        vc_pingpong_bank_fsm
`ifdef VC_PINGPONG_FLUSH_EN
            #(.LEN_SZ(LEN_SZ))
`endif
        u_fsm (
            .clk      (clk),
            .reset_p  (reset_p),
            .wr_fire  (bank_wr_fire[gi]),
            .wr_last  (bank_wr_last[gi]),
            .rd_fire  (bank_rd_fire[gi]),
            .rd_last  (rd_at_last),
`ifdef VC_PINGPONG_FLUSH_EN
            .wr_len   (wr_len),
            .len      (bank_len[gi]),
`endif
            .writable (writable[gi]),
            .readable (readable[gi])
        );

        vcRAM_1w1r_pf #(
            .DATA_SZ (DATA_SZ),
            .ENTRIES (ENTRIES),
            .ADDR_SZ (ADDR_SZ)
        ) u_ram (
            .clk     (clk),
            .wr_en   (bank_wr_fire[gi]),
            .wr_addr (waddr_q),
            .wr_data (in_data),
            .rd_addr (raddr_q),
            .rd_data (rd_data[gi])
        );
    end

endmodule

// File: tb/tb_vc_pingpong_buf_ctrl.sv
// Bench for vc_pingpong_buf_ctrl (ENTRIES=4, DATA_SZ=8). A frame-level
// reference model tracks held frames, the partial frame and queued words.
module tb_vc_pingpong_buf_ctrl;

    localparam int DW = 8;
    localparam int NE = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_p = 1'b1;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_data = '0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    frames_avail;
`ifdef VC_PINGPONG_FLUSH_EN
    logic          flush_p = 1'b0;
`endif

    always #5 clk = ~clk;

    vc_pingpong_buf_ctrl #(.DATA_SZ(DW), .ENTRIES(NE), .ADDR_SZ(AW)) dut (
        .clk          (clk),
        .reset_p      (reset_p),
`ifdef VC_PINGPONG_FLUSH_EN
        .flush_p      (flush_p),
`endif
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_data      (in_data),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .out_last     (out_last),
        .frames_avail (frames_avail)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] m_data[$];
    int            m_len[$];
    int            m_partial = 0;
    int            m_frames  = 0;
    int            m_rdpos   = 0;
    int            m_words_in = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one clock: drive, compare against the model, then advance the model
    task automatic step(input logic rst, input logic iv, input logic [DW-1:0] id,
                        input logic ordy, input logic fl);
        logic e_in_rdy, e_out_val, e_last, w, r, fl_eff;
        @(negedge clk);
        reset_p = rst;
        in_val  = iv;
        in_data = id;
        out_rdy = ordy;
`ifdef VC_PINGPONG_FLUSH_EN
        flush_p = fl;
        fl_eff  = fl;
`else
        fl_eff  = 1'b0;
`endif
        #1;
        e_in_rdy  = !rst && (m_partial > 0 || (m_frames + (m_partial > 0 ? 1 : 0)) < 2);
        e_out_val = !rst && (m_frames > 0);
        e_last    = e_out_val && (m_rdpos == m_len[0] - 1);
        check_val("in_rdy", 32'(in_rdy), 32'(e_in_rdy));
        check_val("out_val", 32'(out_val), 32'(e_out_val));
        check_val("out_last", 32'(out_last), 32'(e_last));
        check_val("frames_avail", 32'(frames_avail), rst ? 32'd0 : 32'(m_frames));
        if (e_out_val) check_val("out_data", 32'(out_data), 32'(m_data[0]));
        w = iv && e_in_rdy;
        r = ordy && e_out_val;
        @(posedge clk);
        if (rst) begin
            m_data.delete();
            m_len.delete();
            m_partial = 0;
            m_frames  = 0;
            m_rdpos   = 0;
        end else begin
            if (r) begin
                void'(m_data.pop_front());
                m_rdpos++;
                if (m_rdpos == m_len[0]) begin
                    m_rdpos = 0;
                    void'(m_len.pop_front());
                    m_frames--;
                end
            end
            if (w) begin
                m_data.push_back(id);
                m_partial++;
                m_words_in++;
            end
            if (m_partial == NE || (fl_eff && m_partial > 0)) begin
                m_len.push_back(m_partial);
                m_partial = 0;
                m_frames++;
            end
        end
    endtask

    initial begin
        // reset, fill both banks with the consumer stalled
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < NE; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < NE; i++) step(0, 1, 8'(8'h20 + i), 0, 0);
        step(0, 1, 8'h99, 0, 0);
        step(0, 1, 8'h99, 0, 0);
        // consumer drains; producer refills as soon as bank 0 frees
        for (int i = 0; i < 12; i++) step(0, 1, 8'(8'h40 + i), 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);

        // continuous streaming, 5 frames
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5 * NE; i++) step(0, 1, 8'(8'h60 + i), 1, 0);
        for (int i = 0; i < NE + 1; i++) step(0, 0, 8'h00, 1, 0);

        // reset mid-frame with bank 0 full and 2 words in bank 1
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < NE + 2; i++) step(0, 1, 8'(8'h80 + i), 0, 0);
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < NE; i++) step(0, 1, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < NE + 1; i++) step(0, 0, 8'h00, 1, 0);

        // random handshakes, 200 accepted words
        step(1, 0, 8'h00, 0, 0);
        m_words_in = 0;
        for (int c = 0; c < 3000 && m_words_in < 200; c++)
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0);
        check_val("rand_words_in", 32'(m_words_in), 32'd200);
        for (int i = 0; i < 3 * NE; i++) step(0, 0, 8'h00, 1, 0);

`ifdef VC_PINGPONG_FLUSH_EN
        // flush after two words, then flush on a write, then a full frame
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h30, 0, 0);
        step(0, 1, 8'h31, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h38, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < NE; i++) step(0, 1, 8'(8'h50 + i), 1, 0);
        for (int c = 0; c < 400; c++)
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));
        for (int i = 0; i < 3 * NE; i++) step(0, 0, 8'h00, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
